adc_scan_ctrl: RTL and testbench
================================

Name: adc_scan_ctrl

Overview:
- Upstream sequencer for the averaging ADC sampler stage in the gas-identification front end.
- Walks a 16-bit channel mask of the memristor sensor array and issues one start/chan/dly/num_b request per enabled channel.
- Collects each averaged 12-bit result into a 16-entry result bank.
- Runs single-shot or periodic frames and signals frame completion to the host/UART side.

Parameters:
CNT_1US, 50, clk cycles per microsecond (50 MHz clk)
CNT_1MS, 50000, clk cycles per millisecond
TIMEOUT_MS, 100, max ms waited for ad_done per channel before error
MAX_NUM_B, 7, upper clamp for averaging exponent (2^7 samples, fits 19-bit accumulator downstream)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
scan_trig  in  1  one-cycle pulse; starts a single frame when idle
scan_en  in  1  level; continuous periodic scanning while high
ch_mask  in  16  bit i = scan channel i; latched at frame start
settle_us  in  16  per-channel settle delay forwarded as ad_dly
avg_b  in  5  averaging exponent forwarded as ad_num_b
period_ms  in  16  gap between frame end and next frame start in continuous mode
ad_start  out  1  one-cycle start pulse to sampler
ad_chan  out  4  channel index for sampler
ad_dly  out  16  settle delay for sampler
ad_num_b  out  5  averaging exponent for sampler
ad_data  in  12  averaged result from sampler
ad_done  in  1  one-cycle result-valid pulse from sampler
res_valid  out  1  one-cycle pulse per stored result
res_chan  out  4  channel of res_data
res_data  out  12  stored result
frame_done  out  1  one-cycle pulse at end of each frame
frame_cnt  out  16  completed-frame counter, wraps 0xFFFF->0
busy  out  1  high from frame start until return to IDLE/GAP
err  out  1  sticky timeout flag, cleared only by reset
rd_addr  in  4  result bank read address
rd_data  out  12  registered read data

Behaviour:
- Reset values: every output 0; result bank all 0; state IDLE.
- States: IDLE, PICK, START, WAIT, STORE, FEND, GAP.
- IDLE -> PICK on scan_trig or scan_en.
  - Frame start latches ch_mask, settle_us, avg_b; sets idx=0 and busy=1.
  - scan_trig while not IDLE is ignored.
- PICK: evaluates one index per cycle.
  - mask[idx]=1 -> START.
  - mask[idx]=0: idx==15 -> FEND, else idx+1 and stay in PICK.
- START: exactly one cycle; ad_start=1.
  - ad_chan=idx; ad_dly=latched settle_us, with 0 forwarded as 1.
  - ad_num_b=min(avg_b, MAX_NUM_B).
  - ad_chan, ad_dly and ad_num_b hold stable until the next START.
  - Next state: WAIT; clear the timeout counters.
- WAIT: timeout runs on a us/ms prescaler from CNT_1US and CNT_1MS.
  - ad_done -> STORE with ad_data captured.
  - Timeout reaching TIMEOUT_MS -> STORE with 12'hFFF captured; err set.
  - ad_done and timeout in the same cycle: ad_done wins.
  - ad_done outside WAIT is ignored.
- STORE: one cycle.
  - bank[idx] <= captured value.
  - res_valid=1, res_chan=idx, res_data=captured value.
  - idx==15 -> FEND, else idx+1 -> PICK.
- FEND: one cycle; frame_done=1; frame_cnt+1.
  - scan_en=1 and period_ms>0 -> GAP.
  - scan_en=1 and period_ms==0 -> PICK, with a new frame start latch.
  - Otherwise -> IDLE with busy=0.
- GAP: busy=0; counts period_ms milliseconds.
  - Expiry with scan_en=1 -> PICK, with a new frame start latch.
  - scan_en dropping -> IDLE immediately.
  - scan_trig in GAP is ignored.
- scan_en dropping mid-frame: the current frame completes, then IDLE.
- Mask all zero: 16 PICK cycles, no ad_start, then frame_done pulses and frame_cnt increments.
- Frame latency with mask=0x0001: ad_start 1 cycle after PICK(0).
  - res_valid 1 cycle after ad_done.
  - frame_done 16 cycles after res_valid: 15 PICK cycles plus FEND.
- Read port: rd_data <= bank[rd_addr] each clk, giving 1-cycle latency.
  - Read and write to the same address in the same cycle returns the old value.
- Mid-operation reset: all state returns to reset values immediately, and ad_start drops asynchronously.

Test Plan:
- scan_trig, mask=0x0005, settle_us=10, avg_b=2, sampler model returns 0x123 then 0x456.
  - Required: exactly two ad_start pulses, on chan 0 and chan 2, each with ad_dly=10 and ad_num_b=2.
  - Required: res_valid reports 0/0x123 then 2/0x456; one frame_done; frame_cnt=1.
  - Required: rd_addr=2 gives 0x456 one cycle later.
- mask=0x0000 with scan_trig -> no ad_start; frame_done 17 cycles after trigger (16 PICK + FEND); busy low afterwards.
- settle_us=0, avg_b=12 -> ad_dly=1, ad_num_b=7.
- Sampler never asserts ad_done on chan 1, mask=0x0003.
  - Required: after 100 ms, bank[1]=0xFFF and err=1.
  - Required: the frame still completes; err stays set through further frames.
- scan_en=1, period_ms=2, mask=0x8000.
  - Required: consecutive frame_done pulses separated by 2 ms + conversion time.
  - Required: clearing scan_en mid-frame yields one further frame_done, then IDLE.
- rst_n asserted during WAIT -> ad_start, busy, res_valid, frame_done = 0; frame_cnt=0; bank cleared; next scan_trig starts cleanly.

Source files
------------

// File: rtl/adc_scan_ctrl.sv
// -----------------------------------------------------------------------------
// adc_scan_ctrl
//
// Upstream sequencer for the averaging ADC sampler in the gas-identification
// front end. A frame walks a 16-bit channel mask of the memristor sensor
// array. For every enabled channel it issues one start/chan/dly/num_b request
// to the sampler, waits for the averaged 12-bit result and stores it in a
// 16-entry result bank. Frames run once per scan_trig, or periodically while
// scan_en is high, with a programmable millisecond gap between frames.
//
// Ports
//   clk, rst_n              system clock; asynchronous active-low reset
//   scan_trig               one-cycle pulse, starts a single frame when idle
//   scan_en                 level, continuous periodic scanning while high
//   ch_mask[15:0]           channel enable mask, latched at frame start
//   settle_us[15:0]         settle delay, latched at frame start
//   avg_b[4:0]              averaging exponent, latched at frame start
//   period_ms[15:0]         gap between frame end and next frame start
//   ad_start                one-cycle request pulse to the sampler
//   ad_chan/ad_dly/ad_num_b request fields, stable until the next ad_start
//   ad_data[11:0], ad_done  averaged result and its one-cycle valid pulse
//   res_valid               one-cycle pulse per stored result
//   res_chan, res_data      channel and value of the stored result
//   frame_done              one-cycle pulse at the end of every frame
//   frame_cnt[15:0]         completed-frame counter, wraps to 0
//   busy                    high while a frame is in progress
//   err                     sticky sampler-timeout flag, cleared by reset only
//   rd_addr, rd_data        result bank read port, one cycle latency
// -----------------------------------------------------------------------------
module adc_scan_ctrl #(
    parameter int CNT_1US    = 50,
    parameter int CNT_1MS    = 50000,
    parameter int TIMEOUT_MS = 100,
    parameter int MAX_NUM_B  = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scan_trig,
    input  logic        scan_en,
    input  logic [15:0] ch_mask,
    input  logic [15:0] settle_us,
    input  logic [4:0]  avg_b,
    input  logic [15:0] period_ms,
    output logic        ad_start,
    output logic [3:0]  ad_chan,
    output logic [15:0] ad_dly,
    output logic [4:0]  ad_num_b,
    input  logic [11:0] ad_data,
    input  logic        ad_done,
    output logic        res_valid,
    output logic [3:0]  res_chan,
    output logic [11:0] res_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        busy,
    output logic        err,
    input  logic [3:0]  rd_addr,
    output logic [11:0] rd_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PICK  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_STORE = 3'd4;
    localparam logic [2:0] S_FEND  = 3'd5;
    localparam logic [2:0] S_GAP   = 3'd6;

    localparam logic [15:0] US_LAST  = 16'(CNT_1US - 1);
    localparam logic [15:0] UPM_LAST = 16'(CNT_1MS / CNT_1US - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_MS - 1);
    localparam logic [4:0]  NUMB_MAX = 5'(MAX_NUM_B);
    localparam logic [11:0] TMO_CODE = 12'hFFF;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [3:0]  idx;
    logic [15:0] mask_q;
    logic [15:0] settle_q;
    logic [4:0]  avg_q;
    logic        frame_start;

    logic [15:0] us_cnt;
    logic [15:0] us_in_ms;
    logic [15:0] ms_cnt;
    logic        us_tick;
    logic        ms_tick;
    logic        wait_timeout;
    logic        gap_expire;

    logic [11:0] bank [16];

    // The single prescaler is shared by the sampler timeout (WAIT) and the
    // inter-frame gap (GAP); it only ever runs in one of them at a time.
    assign us_tick      = (us_cnt == US_LAST);
    assign ms_tick      = us_tick && (us_in_ms == UPM_LAST);
    assign wait_timeout = ms_tick && (ms_cnt == TMO_LAST);
    assign gap_expire   = ms_tick && (({1'b0, ms_cnt} + 17'd1) >= {1'b0, period_ms});

    // Frame start happens on every entry into PICK except the internal
    // PICK->PICK walk and STORE->PICK continuation within a frame.
    assign frame_start = (state_nxt == S_PICK) && (state != S_PICK) && (state != S_STORE);

    // Strobe outputs decode straight from the state register so that they
    // drop as soon as the asynchronous reset clears the state.
    assign ad_start   = (state == S_START);
    assign res_valid  = (state == S_STORE);
    assign frame_done = (state == S_FEND);
    assign busy       = (state == S_PICK) || (state == S_START) || (state == S_WAIT) ||
                        (state == S_STORE) || (state == S_FEND);

    // Next-state logic. ad_done is checked ahead of the timeout so a result
    // arriving on the timeout cycle is still taken as a real conversion.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (scan_trig || scan_en) begin
                    state_nxt = S_PICK;
                end
            end
            S_PICK: begin
                if (mask_q[idx]) begin
                    state_nxt = S_START;
                end else if (idx == 4'd15) begin
                    state_nxt = S_FEND;
                end
            end
            S_START: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (ad_done || wait_timeout) begin
                    state_nxt = S_STORE;
                end
            end
            S_STORE: begin
                state_nxt = (idx == 4'd15) ? S_FEND : S_PICK;
            end
            S_FEND: begin
                if (scan_en) begin
                    state_nxt = (period_ms != 16'd0) ? S_GAP : S_PICK;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (!scan_en) begin
                    state_nxt = S_IDLE;
                end else if (gap_expire) begin
                    state_nxt = S_PICK;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Prescaler: microsecond counter, microseconds-per-millisecond counter and
    // elapsed milliseconds. Held at zero outside WAIT and GAP so each wait or
    // gap always measures from a clean start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            us_cnt   <= '0;
            us_in_ms <= '0;
            ms_cnt   <= '0;
        end else if ((state != S_WAIT) && (state != S_GAP)) begin
            us_cnt   <= '0;
            us_in_ms <= '0;
            ms_cnt   <= '0;
        end else begin
            us_cnt <= us_tick ? 16'd0 : us_cnt + 16'd1;
            if (us_tick) begin
                us_in_ms <= (us_in_ms == UPM_LAST) ? 16'd0 : us_in_ms + 16'd1;
            end
            if (ms_tick) begin
                ms_cnt <= ms_cnt + 16'd1;
            end
        end
    end

    // Frame configuration and channel walk. The request fields are loaded on
    // the PICK->START step so they are valid with ad_start and then held for
    // the sampler until the next request. A zero settle time is forwarded as
    // one microsecond and the averaging exponent is clamped to what the
    // downstream accumulator can hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q   <= '0;
            settle_q <= '0;
            avg_q    <= '0;
            idx      <= '0;
            ad_chan  <= '0;
            ad_dly   <= '0;
            ad_num_b <= '0;
        end else if (frame_start) begin
            mask_q   <= ch_mask;
            settle_q <= settle_us;
            avg_q    <= avg_b;
            idx      <= '0;
        end else if (state == S_PICK) begin
            if (mask_q[idx]) begin
                ad_chan  <= idx;
                ad_dly   <= (settle_q == 16'd0) ? 16'd1 : settle_q;
                ad_num_b <= (avg_q > NUMB_MAX) ? NUMB_MAX : avg_q;
            end else if (idx != 4'd15) begin
                idx <= idx + 4'd1;
            end
        end else if ((state == S_STORE) && (idx != 4'd15)) begin
            idx <= idx + 4'd1;
        end
    end

    // Result capture. res_chan/res_data are loaded when WAIT resolves so they
    // are valid during the STORE cycle that pulses res_valid; a timeout stores
    // the all-ones code and raises the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_chan <= '0;
            res_data <= '0;
            err      <= 1'b0;
        end else if (state == S_WAIT) begin
            if (ad_done) begin
                res_chan <= idx;
                res_data <= ad_data;
            end else if (wait_timeout) begin
                res_chan <= idx;
                res_data <= TMO_CODE;
                err      <= 1'b1;
            end
        end
    end

    // Completed-frame counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (state == S_FEND) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Result bank with registered read port. The read samples the bank before
    // the same-edge write lands, so a simultaneous read of the written address
    // returns the previous value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                bank[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (state == S_STORE) begin
                bank[idx] <= res_data;
            end
            rd_data <= bank[rd_addr];
        end
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adc_scan_ctrl
//
// Directed bench for adc_scan_ctrl. The DUT runs with a shortened time base
// (2 clk per us, 20 clk per ms, 5 ms timeout) so timeouts and frame gaps fit
// in a short simulation. A sampler model answers each ad_start after a fixed
// latency with a per-channel value; a monitor logs every strobe with its
// cycle number so the scenario tasks can check counts, fields and latencies.
// -----------------------------------------------------------------------------
module tb_adc_scan_ctrl;

    localparam int CLK_HALF = 10;
    localparam int T_US     = 2;
    localparam int T_MS     = 20;
    localparam int T_TMO    = 5;
    localparam int SAMP_LAT = 3;
    localparam int LOGN     = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scan_trig;
    logic        scan_en;
    logic [15:0] ch_mask;
    logic [15:0] settle_us;
    logic [4:0]  avg_b;
    logic [15:0] period_ms;
    logic        ad_start;
    logic [3:0]  ad_chan;
    logic [15:0] ad_dly;
    logic [4:0]  ad_num_b;
    logic [11:0] ad_data;
    logic        ad_done;
    logic        res_valid;
    logic [3:0]  res_chan;
    logic [11:0] res_data;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        busy;
    logic        err;
    logic [3:0]  rd_addr;
    logic [11:0] rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic samp_mute;
    logic drop_ch1;
    logic [3:0] samp_ch;

    int          cyc = 0;
    int          trig_cyc = 0;
    int          done_cyc = 0;
    int          n_start = 0;
    int          n_res = 0;
    int          n_fd = 0;
    logic [3:0]  st_chan [LOGN];
    logic [15:0] st_dly  [LOGN];
    logic [4:0]  st_numb [LOGN];
    int          st_cyc  [LOGN];
    logic [3:0]  rs_chan [LOGN];
    logic [11:0] rs_data [LOGN];
    int          rs_cyc  [LOGN];
    int          fd_cyc  [LOGN];

    adc_scan_ctrl #(
        .CNT_1US    (T_US),
        .CNT_1MS    (T_MS),
        .TIMEOUT_MS (T_TMO),
        .MAX_NUM_B  (7)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_trig  (scan_trig),
        .scan_en    (scan_en),
        .ch_mask    (ch_mask),
        .settle_us  (settle_us),
        .avg_b      (avg_b),
        .period_ms  (period_ms),
        .ad_start   (ad_start),
        .ad_chan    (ad_chan),
        .ad_dly     (ad_dly),
        .ad_num_b   (ad_num_b),
        .ad_data    (ad_data),
        .ad_done    (ad_done),
        .res_valid  (res_valid),
        .res_chan   (res_chan),
        .res_data   (res_data),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .busy       (busy),
        .err        (err),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #CLK_HALF clk = ~clk;

    // Value the sampler model returns for a channel.
    function automatic logic [11:0] resp_for(input logic [3:0] ch);
        case (ch)
            4'd0:    return 12'h123;
            4'd2:    return 12'h456;
            default: return {8'hA0, ch};
        endcase
    endfunction

    // Sampler model: answers ad_start after SAMP_LAT clocks unless muted or
    // told to ignore channel 1.
    initial begin
        ad_done = 1'b0;
        ad_data = '0;
        forever begin
            @(negedge clk);
            if (ad_start === 1'b1 && !samp_mute && !(drop_ch1 && ad_chan == 4'd1)) begin
                samp_ch = ad_chan;
                repeat (SAMP_LAT) @(posedge clk);
                #1;
                ad_data = resp_for(samp_ch);
                ad_done = 1'b1;
                @(posedge clk);
                #1;
                ad_done = 1'b0;
            end
        end
    end

    // Strobe monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (scan_trig === 1'b1) trig_cyc = cyc;
            if (ad_done === 1'b1) done_cyc = cyc;
            if (ad_start === 1'b1 && n_start < LOGN) begin
                st_chan[n_start] = ad_chan;
                st_dly[n_start]  = ad_dly;
                st_numb[n_start] = ad_num_b;
                st_cyc[n_start]  = cyc;
                n_start++;
            end
            if (res_valid === 1'b1 && n_res < LOGN) begin
                rs_chan[n_res] = res_chan;
                rs_data[n_res] = res_data;
                rs_cyc[n_res]  = cyc;
                n_res++;
            end
            if (frame_done === 1'b1 && n_fd < LOGN) begin
                fd_cyc[n_fd] = cyc;
                n_fd++;
            end
        end
    end

    initial begin
        #(2 * CLK_HALF * 60000);
        $display("[TB] FAIL watchdog: simulation still running, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_trig();
        scan_trig = 1'b1;
        step();
        scan_trig = 1'b0;
    endtask

    task automatic wait_fd(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            at_neg();
            if (n_fd >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_start(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            at_neg();
            if (n_start >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        scan_trig = 1'b0;
        scan_en = 1'b0;
        ch_mask = '0;
        settle_us = '0;
        avg_b = '0;
        period_ms = '0;
        rd_addr = '0;
        samp_mute = 1'b0;
        drop_ch1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({ad_start, res_valid, frame_done, busy, err} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_strobes: got %b expected 00000", {ad_start, res_valid, frame_done, busy, err});
        end
        n_checks++;
        if ({ad_chan, ad_dly, ad_num_b} !== 25'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_req: got %h expected 0", {ad_chan, ad_dly, ad_num_b});
        end
        n_checks++;
        if ({res_chan, res_data, frame_cnt, rd_data} !== 44'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got %h expected 0", {res_chan, res_data, frame_cnt, rd_data});
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        int bs, br, bf;
        bit ok;
        bs = n_start; br = n_res; bf = n_fd;
        ch_mask = 16'h0005; settle_us = 16'd10; avg_b = 5'd2;
        pulse_trig();
        wait_fd(bf + 1, 400, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("[TB] FAIL single_fd_wait: got timeout expected frame_done"); end
        repeat (5) step();
        n_checks++;
        if (n_start - bs != 2) begin n_fail++; $display("[TB] FAIL single_nstart: got %0d expected 2", n_start - bs); end
        n_checks++;
        if ({st_chan[bs], st_chan[bs+1]} !== 8'h02) begin
            n_fail++; $display("[TB] FAIL single_chans: got %h expected 02", {st_chan[bs], st_chan[bs+1]});
        end
        n_checks++;
        if ({st_dly[bs], st_numb[bs], st_dly[bs+1], st_numb[bs+1]} !== {16'd10, 5'd2, 16'd10, 5'd2}) begin
            n_fail++; $display("[TB] FAIL single_dly_numb: got %0d/%0d %0d/%0d expected 10/2 10/2",
                               st_dly[bs], st_numb[bs], st_dly[bs+1], st_numb[bs+1]);
        end
        n_checks++;
        if (st_cyc[bs] - trig_cyc != 2) begin
            n_fail++; $display("[TB] FAIL single_start_lat: got %0d expected 2", st_cyc[bs] - trig_cyc);
        end
        n_checks++;
        if (n_res - br != 2 || {rs_chan[br], rs_data[br], rs_chan[br+1], rs_data[br+1]} !== {4'd0, 12'h123, 4'd2, 12'h456}) begin
            n_fail++; $display("[TB] FAIL single_results: got n=%0d %0d/%h %0d/%h expected n=2 0/123 2/456",
                               n_res - br, rs_chan[br], rs_data[br], rs_chan[br+1], rs_data[br+1]);
        end
        n_checks++;
        if (n_fd - bf != 1 || frame_cnt !== 16'd1) begin
            n_fail++; $display("[TB] FAIL single_frame: got fd=%0d cnt=%0d expected fd=1 cnt=1", n_fd - bf, frame_cnt);
        end
        rd_addr = 4'd2;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rd_data !== 12'h456) begin n_fail++; $display("[TB] FAIL single_rd2: got %h expected 456", rd_data); end
        step();
        rd_addr = 4'd1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rd_data !== 12'h000) begin n_fail++; $display("[TB] FAIL single_rd1: got %h expected 000", rd_data); end
        step();
    endtask

    task automatic test_empty_mask();
        int bs, bf;
        bit ok;
        bs = n_start; bf = n_fd;
        ch_mask = 16'h0000;
        pulse_trig();
        wait_fd(bf + 1, 100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("[TB] FAIL empty_fd_wait: got timeout expected frame_done"); end
        n_checks++;
        if (fd_cyc[bf] - trig_cyc != 17) begin
            n_fail++; $display("[TB] FAIL empty_latency: got %0d expected 17", fd_cyc[bf] - trig_cyc);
        end
        repeat (3) step();
        n_checks++;
        if (n_start != bs || busy !== 1'b0 || frame_cnt !== 16'd2) begin
            n_fail++; $display("[TB] FAIL empty_after: got starts=%0d busy=%b cnt=%0d expected 0 0 2", n_start - bs, busy, frame_cnt);
        end
    endtask

    task automatic test_clamp();
        int bs, br, bf;
        bit ok;
        bs = n_start; br = n_res; bf = n_fd;
        ch_mask = 16'h0001; settle_us = 16'd0; avg_b = 5'd12;
        pulse_trig();
        wait_fd(bf + 1, 300, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("[TB] FAIL clamp_fd_wait: got timeout expected frame_done"); end
        n_checks++;
        if ({st_chan[bs], st_dly[bs], st_numb[bs]} !== {4'd0, 16'd1, 5'd7}) begin
            n_fail++; $display("[TB] FAIL clamp_req: got chan=%0d dly=%0d numb=%0d expected 0 1 7", st_chan[bs], st_dly[bs], st_numb[bs]);
        end
        n_checks++;
        if (rs_cyc[br] - done_cyc != 1) begin
            n_fail++; $display("[TB] FAIL clamp_res_lat: got %0d expected 1", rs_cyc[br] - done_cyc);
        end
        n_checks++;
        if (fd_cyc[bf] - rs_cyc[br] != 16) begin
            n_fail++; $display("[TB] FAIL clamp_fd_lat: got %0d expected 16", fd_cyc[bf] - rs_cyc[br]);
        end
        step();
        n_checks++;
        if (frame_cnt !== 16'd3) begin n_fail++; $display("[TB] FAIL clamp_cnt: got %0d expected 3", frame_cnt); end
    endtask

    task automatic test_timeout();
        int bs, br, bf;
        bit ok;
        bs = n_start; br = n_res; bf = n_fd;
        ch_mask = 16'h0003; settle_us = 16'd4; avg_b = 5'd3;
        drop_ch1 = 1'b1;
        pulse_trig();
        wait_fd(bf + 1, 600, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("[TB] FAIL tmo_fd_wait: got timeout expected frame_done"); end
        n_checks++;
        if ({rs_chan[br], rs_data[br], rs_chan[br+1], rs_data[br+1]} !== {4'd0, 12'h123, 4'd1, 12'hFFF}) begin
            n_fail++; $display("[TB] FAIL tmo_results: got %0d/%h %0d/%h expected 0/123 1/fff",
                               rs_chan[br], rs_data[br], rs_chan[br+1], rs_data[br+1]);
        end
        // START cycle, then 5 ms x 20 clk of WAIT, then STORE.
        n_checks++;
        if (rs_cyc[br+1] - st_cyc[bs+1] != 1 + T_TMO * T_MS) begin
            n_fail++; $display("[TB] FAIL tmo_latency: got %0d expected %0d", rs_cyc[br+1] - st_cyc[bs+1], 1 + T_TMO * T_MS);
        end
        step();
        n_checks++;
        if (err !== 1'b1 || ad_chan !== 4'd1) begin
            n_fail++; $display("[TB] FAIL tmo_err_hold: got err=%b chan=%0d expected 1 1", err, ad_chan);
        end
        rd_addr = 4'd1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rd_data !== 12'hFFF) begin n_fail++; $display("[TB] FAIL tmo_bank1: got %h expected fff", rd_data); end
        step();
        drop_ch1 = 1'b0;
        ch_mask = 16'h0001;
        pulse_trig();
        wait_fd(bf + 2, 300, ok);
        step();
        n_checks++;
        if (!ok || err !== 1'b1 || frame_cnt !== 16'd5) begin
            n_fail++; $display("[TB] FAIL tmo_sticky: got ok=%0d err=%b cnt=%0d expected 1 1 5", ok, err, frame_cnt);
        end
    endtask

    task automatic test_periodic();
        int bf, bs;
        bit ok;
        bf = n_fd;
        ch_mask = 16'h8000; settle_us = 16'd5; avg_b = 5'd1; period_ms = 16'd2;
        scan_en = 1'b1;
        wait_fd(bf + 3, 1500, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("[TB] FAIL per_fd_wait: got timeout expected 3 frame_done"); end
        // Gap 2 ms (40) + 16 PICK + START + 3 WAIT + STORE + FEND = 62 cycles.
        n_checks++;
        if (fd_cyc[bf+1] - fd_cyc[bf] != 62 || fd_cyc[bf+2] - fd_cyc[bf+1] != 62) begin
            n_fail++; $display("[TB] FAIL per_interval: got %0d %0d expected 62 62",
                               fd_cyc[bf+1] - fd_cyc[bf], fd_cyc[bf+2] - fd_cyc[bf+1]);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL per_gap_busy: got %b expected 0", busy); end
        bs = n_start;
        wait_start(bs + 1, 200, ok);
        step();
        scan_en = 1'b0;
        bf = n_fd;
        wait_fd(bf + 1, 100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("[TB] FAIL per_last_frame: got timeout expected frame_done"); end
        repeat (100) step();
        n_checks++;
        if (n_fd != bf + 1 || n_start != bs + 1 || busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL per_stop: got fd=%0d starts=%0d busy=%b expected 1 1 0", n_fd - bf, n_start - bs, busy);
        end
        period_ms = 16'd0;
    endtask

    task automatic test_mid_reset();
        int bs, br, bf;
        bit ok;
        samp_mute = 1'b1;
        ch_mask = 16'h0001;
        bs = n_start;
        pulse_trig();
        wait_start(bs + 1, 100, ok);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ad_start, busy, res_valid, frame_done} !== 4'b0) begin
            n_fail++; $display("[TB] FAIL rst_strobes: got %b expected 0000", {ad_start, busy, res_valid, frame_done});
        end
        n_checks++;
        if (frame_cnt !== 16'd0 || err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rst_cnt_err: got cnt=%0d err=%b expected 0 0", frame_cnt, err);
        end
        repeat (2) step();
        rst_n = 1'b1;
        samp_mute = 1'b0;
        rd_addr = 4'd15;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rd_data !== 12'h000) begin n_fail++; $display("[TB] FAIL rst_bank15: got %h expected 000", rd_data); end
        step();
        rd_addr = 4'd1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rd_data !== 12'h000) begin n_fail++; $display("[TB] FAIL rst_bank1: got %h expected 000", rd_data); end
        step();
        bs = n_start; br = n_res; bf = n_fd;
        ch_mask = 16'h0004;
        pulse_trig();
        wait_fd(bf + 1, 300, ok);
        step();
        n_checks++;
        if (!ok || n_start - bs != 1 || rs_chan[br] !== 4'd2 || rs_data[br] !== 12'h456 || frame_cnt !== 16'd1) begin
            n_fail++; $display("[TB] FAIL rst_restart: got ok=%0d starts=%0d res=%0d/%h cnt=%0d expected 1 1 2/456 1",
                               ok, n_start - bs, rs_chan[br], rs_data[br], frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_empty_mask();
        test_clamp();
        test_timeout();
        test_periodic();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
